// File: rtl/seg7_capture.sv
// Seven-segment scan capture: debounces {Pol, DigitEn, Segment}, decodes each
// stable digit and emits a 16-bit hex frame once all four digits are seen.
module seg7_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        Clk,
  input  logic        nRst,
  input  logic [6:0]  Segment,
  input  logic [3:0]  DigitEn,
  input  logic        Pol,
  output logic [15:0] Value,
  output logic        Valid,
  output logic        Error
);

  typedef enum logic {COLLECT, DONE} state_e;

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  state_e      state_q, state_d;
  logic [11:0] samp_q, prev_q;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  mask_q, mask_d;
  logic [3:0]  inv_q, inv_d;
  logic [15:0] nib_q, nib_d;
  logic [15:0] value_q;
  logic        error_q;

  logic [3:0]  de;
  logic [6:0]  seg_hi;
  logic [4:0]  dec;
  logic        win, onehot, cap;

  // Returns {invalid, nibble}; unknown patterns decode to nibble 0.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h3F: decode = 5'h00;
      7'h06: decode = 5'h01;
      7'h5B: decode = 5'h02;
      7'h4F: decode = 5'h03;
      7'h66: decode = 5'h04;
      7'h6D: decode = 5'h05;
      7'h7D: decode = 5'h06;
      7'h07: decode = 5'h07;
      7'h7F: decode = 5'h08;
      7'h6F: decode = 5'h09;
      7'h77: decode = 5'h0A;
      7'h7C: decode = 5'h0B;
      7'h39: decode = 5'h0C;
      7'h5E: decode = 5'h0D;
      7'h79: decode = 5'h0E;
      7'h71: decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  assign de     = samp_q[10:7];
  assign seg_hi = samp_q[11] ? samp_q[6:0] : ~samp_q[6:0];
  assign dec    = decode(seg_hi);
  assign onehot = (de != 4'd0) && ((de & (de - 4'd1)) == 4'd0);

  always_comb begin
    cnt_d = 4'd1;
    if (samp_q == prev_q) cnt_d = (cnt_q == STABLE) ? cnt_q : cnt_q + 4'd1;
  end

  // A window fires only on the cycle the counter reaches saturation.
  assign win = (cnt_d == STABLE) && (cnt_q != STABLE);
  assign cap = win && (state_q == COLLECT) && onehot && ((mask_q & de) == 4'd0);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    inv_d   = inv_q;
    nib_d   = nib_q;
    case (state_q)
      COLLECT: begin
        if (mask_q == 4'hF) state_d = DONE;
        for (int i = 0; i < 4; i++) begin
          if (cap && de[i]) begin
            mask_d[i]       = 1'b1;
            inv_d[i]        = dec[4];
            nib_d[i*4 +: 4] = dec[3:0];
          end
        end
      end
      DONE: begin
        state_d = COLLECT;
        mask_d  = 4'd0;
        inv_d   = 4'd0;
        nib_d   = 16'd0;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= COLLECT;
      samp_q  <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      inv_q   <= '0;
      nib_q   <= '0;
      value_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      samp_q  <= {Pol, DigitEn, Segment};
      prev_q  <= samp_q;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      inv_q   <= inv_d;
      nib_q   <= nib_d;
      if (state_d == DONE && state_q == COLLECT) begin
        value_q <= nib_q;
        error_q <= |inv_q;
      end
    end
  end

  assign Value = value_q;
  assign Error = error_q;
  assign Valid = (state_q == DONE);

endmodule

// File: tb/tb_seg7_capture.sv
// Randomized scoreboard bench for seg7_capture against a run-length reference model.
module tb_seg7_capture;
  localparam int STABLE = 4;

  logic        Clk = 1'b0;
  logic        nRst = 1'b0;
  logic [6:0]  Segment = '0;
  logic [3:0]  DigitEn = '0;
  logic        Pol = 1'b0;
  logic [15:0] Value;
  logic        Valid;
  logic        Error;

  seg7_capture #(.STABLE_CYCLES(STABLE)) dut (
    .Clk(Clk), .nRst(nRst), .Segment(Segment), .DigitEn(DigitEn), .Pol(Pol),
    .Value(Value), .Valid(Valid), .Error(Error)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_valid = 0;
  logic [16:0] exp_q[$];

  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  // Reference model: one step per sampled input cycle.
  logic [11:0] m_last;
  int          m_run;
  logic [3:0]  m_mask, m_inv;
  logic [3:0]  m_nib [4];
  bit          m_done;

  task automatic model_reset();
    m_last = '0; m_run = 0; m_mask = '0; m_inv = '0; m_done = 0;
    for (int i = 0; i < 4; i++) m_nib[i] = '0;
  endtask

  task automatic model_step(input logic [11:0] v);
    int old_run, d;
    bit hit, found;
    logic [6:0] s;
    logic [3:0] n;
    old_run = m_run;
    if (v == m_last) begin
      if (m_run < STABLE) m_run++;
    end else m_run = 1;
    m_last = v;
    hit = (m_run == STABLE) && (old_run != STABLE);
    if (m_done) begin
      m_done = 0; m_mask = '0; m_inv = '0;
      for (int i = 0; i < 4; i++) m_nib[i] = '0;
    end else if (m_mask == 4'hF) begin
      exp_q.push_back({|m_inv, m_nib[3], m_nib[2], m_nib[1], m_nib[0]});
      m_done = 1;
    end else if (hit && $countones(v[10:7]) == 1) begin
      d = 0;
      for (int i = 0; i < 4; i++) if (v[7+i]) d = i;
      if (!m_mask[d]) begin
        s = v[11] ? v[6:0] : ~v[6:0];
        found = 0; n = 0;
        for (int i = 0; i < 16; i++) if (tbl[i] == s) begin found = 1; n = 4'(i); end
        m_mask[d] = 1'b1;
        m_inv[d]  = !found;
        m_nib[d]  = n;
      end
    end
  endtask

  task automatic drv(input logic p, input logic [3:0] de, input logic [6:0] seg, input int n);
    repeat (n) begin
      @(negedge Clk);
      Pol = p; DigitEn = de; Segment = seg;
      model_step({p, de, seg});
    end
  endtask

  task automatic frame(input logic p, input logic [6:0] s3, input logic [6:0] s2,
                       input logic [6:0] s1, input logic [6:0] s0);
    drv(p, 4'b1000, s3, 6);
    drv(p, 4'b0100, s2, 6);
    drv(p, 4'b0010, s1, 6);
    drv(p, 4'b0001, s0, 6);
    drv(p, 4'b0000, 7'h00, 6);
  endtask

  // Monitor: pop an expected frame for every Valid pulse.
  logic v_prev = 1'b0;
  always @(posedge Clk) begin
    logic [16:0] e;
    #1;
    if (Valid) begin
      n_valid++;
      chk("valid_single_cycle", {31'd0, v_prev}, 32'd0);
      if (exp_q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("frame_value", {16'd0, Value}, {16'd0, e[15:0]});
        chk("frame_error", {31'd0, Error}, {31'd0, e[16]});
      end
    end
    v_prev = Valid;
  end

  initial begin
    logic [3:0] de;
    logic [6:0] seg;
    logic       p;
    model_reset();
    #2;
    chk("reset_value", {16'd0, Value}, 32'd0);
    chk("reset_valid", {31'd0, Valid}, 32'd0);
    chk("reset_error", {31'd0, Error}, 32'd0);
    @(negedge Clk); @(negedge Clk);
    nRst = 1'b1;
    drv(1'b0, 4'b0000, 7'h00, 3);

    frame(1'b1, 7'h06, 7'h5B, 7'h4F, 7'h66);
    chk("const_1234", {16'd0, Value}, 32'h1234);
    chk("const_1234_err", {31'd0, Error}, 32'd0);

    frame(1'b0, 7'h08, 7'h03, 7'h46, 7'h21);
    chk("const_abcd", {16'd0, Value}, 32'hABCD);

    // Glitchy digit 0 (would read 8) and a two-hot select must not capture.
    drv(1'b1, 4'b0001, 7'h7F, STABLE - 1);
    drv(1'b1, 4'b0000, 7'h00, 2);
    drv(1'b1, 4'b0011, 7'h7F, 10);
    frame(1'b1, 7'h06, 7'h5B, 7'h4F, 7'h66);
    chk("const_glitch_1234", {16'd0, Value}, 32'h1234);

    // Digit 2 blank, digit 0 captured as 0 then offered as 1.
    drv(1'b1, 4'b0001, 7'h3F, 6);
    drv(1'b1, 4'b1000, 7'h06, 6);
    drv(1'b1, 4'b0100, 7'h00, 6);
    drv(1'b1, 4'b0001, 7'h06, 6);
    drv(1'b1, 4'b0010, 7'h5B, 6);
    drv(1'b1, 4'b0000, 7'h00, 6);
    chk("const_invalid_value", {16'd0, Value}, 32'h1020);
    chk("const_invalid_err", {31'd0, Error}, 32'd1);

    // Two captures, then an asynchronous reset in the middle of a cycle.
    drv(1'b1, 4'b1000, 7'h7F, 6);
    drv(1'b1, 4'b0100, 7'h6F, 6);
    drv(1'b1, 4'b0000, 7'h00, 4);
    @(negedge Clk);
    #3 nRst = 1'b0;
    #1;
    chk("midreset_value", {16'd0, Value}, 32'd0);
    chk("midreset_valid", {31'd0, Valid}, 32'd0);
    chk("midreset_error", {31'd0, Error}, 32'd0);
    @(negedge Clk);
    nRst = 1'b1;
    model_reset();
    drv(1'b1, 4'b0000, 7'h00, 2);
    drv(1'b1, 4'b0010, 7'h07, 6);
    drv(1'b1, 4'b0001, 7'h7F, 6);
    drv(1'b1, 4'b0000, 7'h00, 6);
    chk("post_reset_partial_hold", {16'd0, Value}, 32'd0);
    frame(1'b1, 7'h6D, 7'h7D, 7'h07, 7'h7F);
    chk("const_5678", {16'd0, Value}, 32'h5678);

    for (int k = 0; k < 400; k++) begin
      p = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) de = 4'(1 << $urandom_range(0, 3));
      else de = 4'($urandom);
      if ($urandom_range(0, 9) < 7) seg = tbl[$urandom_range(0, 15)];
      else seg = 7'($urandom);
      if (!p) seg = ~seg;
      drv(p, de, seg, $urandom_range(1, 7));
    end
    drv(1'b0, 4'b0000, 7'h00, 4);

    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge Clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("some_frames_seen", {31'd0, n_valid > 8}, 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4: the number of consecutive identical samples required before a digit is accepted (legal range 2..15).
REQ-002 Clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 nRst  input  1  reset, asynchronous and active-low.
REQ-004 Segment  input  7  raw segment lines; bit 6..0 = g,f,e,d,c,b,a.
REQ-005 DigitEn  input  4  active-high digit select from the display scanner; bit 3 = most-significant digit.
REQ-006 Pol  input  1  segment polarity: 0 = active-low segments, 1 = active-high segments.
REQ-007 Value  output  16  last completed frame; digit 3 in bits [15:12], digit 0 in bits [3:0].
REQ-008 Valid  output  1  one-cycle pulse when Value and Error update.
REQ-009 Error  output  1  set if any digit of the last completed frame was unrecognised.

Function
REQ-010 The block SHALL register {Pol, DigitEn, Segment} every cycle into a sample register, and the compare logic SHALL use only registered values.
REQ-011 The stability counter SHALL behave as follows:
  - If the new sample equals the previous sample, the counter SHALL increment, saturating at STABLE_CYCLES.
  - Otherwise the counter SHALL load 1.
REQ-012 A capture SHALL occur only on the cycle the counter transitions to STABLE_CYCLES, at most one capture per stable window.
REQ-013 A capture SHALL be suppressed if DigitEn is not one-hot (all zero or multiple bits set).
REQ-014 A capture SHALL be suppressed if the selected digit is already marked captured in the current frame; the first capture wins.
REQ-015 On capture, the block SHALL normalise Segment to active-high (invert when Pol=0) and decode it to a nibble in the digit's slot. Patterns, active-high gfedcba:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
REQ-016 On capture of any pattern not in REQ-015, the block SHALL store nibble 0 and set that digit's invalid flag.
REQ-017 The FSM SHALL have exactly two states:
  - COLLECT: captures accumulate in a 4-bit captured mask.
  - COLLECT -> DONE: on the cycle the mask becomes 4'b1111.
  - DONE: lasts exactly one cycle; Valid=1, Value loads the assembled nibbles, Error loads the OR of the invalid flags, and the mask and flags clear.
  - DONE -> COLLECT: unconditionally.
REQ-018 Latency: Valid SHALL assert exactly one cycle after the fourth capture.
REQ-019 In DONE, no capture SHALL occur; a window completing in DONE SHALL be lost, and the counter SHALL continue normally.
REQ-020 Value and Error SHALL hold between Valid pulses; Valid SHALL be 0 in COLLECT.
REQ-021 A Pol change SHALL count as a sample change and restart stability.
REQ-022 Digit order SHALL be arbitrary; any capture order completing all four digits produces a frame.

Reset
REQ-023 While nRst=0, the following SHALL be forced immediately, independent of Clk:
  - Value=16'h0000, Valid=0, Error=0.
  - Captured mask=0, invalid flags=0, nibbles=0.
  - Counter=0, sample register=0, state=COLLECT.
REQ-024 Reset asserted mid-frame SHALL discard all partial captures; after release, a complete new frame of four captures SHALL be required.
REQ-025 The first sample after reset release SHALL load the counter to 1 (the sample register holds 0 after reset).

Verification
REQ-026 Reset test: assert nRst=0 asynchronously mid-cycle -> Value=0000, Valid=0, Error=0 immediately.
REQ-027 Active-high frame: Pol=1; DigitEn=8,4,2,1 with Segment=06,5B,4F,66, each held 6 cycles -> one Valid pulse, Value=16'h1234, Error=0, Valid one cycle after the 4th capture.
REQ-028 Active-low frame: Pol=0; digits 3..0 with Segment=~77,~7C,~39,~5E (08,03,46,21) -> Value=16'hABCD, Error=0.
REQ-029 Glitch rejection (STABLE_CYCLES=4): digit 0 held STABLE_CYCLES-1 cycles, then changed -> no capture and mask unchanged; DigitEn=4'b0011 held 10 cycles -> no capture.
REQ-030 Invalid and duplicate digits: Pol=1 frame with digit 2 Segment=00 and digit 0 captured twice (first 3F, then 06) -> Value nibble[11:8]=0, nibble[3:0]=0, Error=1 on Valid.
REQ-031 Reset mid-frame: pulse nRst low after two captures, then present all four digits -> exactly one Valid, containing only post-reset digits.
